regfile_dumper: RTL

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_dumper.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dumper
// Purpose  : Streams register-file entries FIRST_REG..LAST_REG out over a
//            valid/ready port, substituting R15 (PC+8) for index 15.
// Revision : 1.0
// ============================================================================
module regfile_dumper #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        ABORT,
   output logic [3:0]  RA,
   input  logic [31:0] RD,
   input  logic [31:0] R15,
   output logic [31:0] DOUT,
   output logic [3:0]  DOUT_IDX,
   output logic        DOUT_VALID,
   input  logic        DOUT_READY,
   output logic        BUSY,
   output logic        DONE
);

   localparam logic [3:0] C_FIRST = 4'(FIRST_REG);
   localparam logic [3:0] C_LAST  = 4'(LAST_REG);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_OUT    = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_idx;
   logic [3:0]  w_idx_nxt;
   logic        w_capture;
   logic [31:0] r_dout;
   logic [3:0]  r_dout_idx;
   logic [31:0] w_rd_sel;

   // The index counter only changes on entry to READ, so it doubles as the
   // registered read address and naturally holds outside READ.
   assign RA       = r_idx;
   assign w_rd_sel = (r_idx == 4'd15) ? R15 : RD;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_idx      <= 4'd0;
         r_dout     <= 32'd0;
         r_dout_idx <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_capture) begin
            r_dout     <= w_rd_sel;
            r_dout_idx <= r_idx;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_state_nxt = S_READ;
               w_idx_nxt   = C_FIRST;
            end
         end
         S_READ: begin
            if (ABORT) begin
               w_state_nxt = S_FINISH;
            end else begin
               w_state_nxt = S_OUT;
               w_capture   = 1'b1;
            end
         end
         S_OUT: begin
            // A handshake coinciding with ABORT still counts as delivered.
            if (DOUT_READY) begin
               if (ABORT || (r_idx == C_LAST)) begin
                  w_state_nxt = S_FINISH;
               end else begin
                  w_state_nxt = S_READ;
                  w_idx_nxt   = r_idx + 4'd1;
               end
            end else if (ABORT) begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign DOUT       = r_dout;
   assign DOUT_IDX   = r_dout_idx;
   assign DOUT_VALID = (r_state == S_OUT);
   assign BUSY       = (r_state != S_IDLE);
   assign DONE       = (r_state == S_FINISH);

endmodule
`default_nettype wire
